// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first, one carry/borrow flop.
// Define OVERFLOW_FLAG_EN to register the signed-overflow flag.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             m,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res_nxt;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             mode;
  logic             s;
  logic             c_nxt;
  logic             last;

  always_comb begin
    s       = sa[0] ^ sb[0] ^ c;
    c_nxt   = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
    last    = (cnt == CW'(WIDTH - 1));
    res_nxt = result >> 1;
    res_nxt[WIDTH-1] = s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sa        <= '0;
      sb        <= '0;
      cnt       <= '0;
      c         <= 1'b0;
      mode      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sa        <= a;
            sb        <= b ^ {WIDTH{m}};
            mode      <= m;
            c         <= m;
            cnt       <= '0;
            carry_out <= 1'b0;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          c      <= c_nxt;
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          result <= res_nxt;
          cnt    <= cnt + CW'(1);
          if (last) begin
            state     <= DONE;
            done      <= 1'b1;
            // carry of a + ~b + 1 is the inverse of the borrow
            carry_out <= mode ? ~c_nxt : c_nxt;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OVERFLOW_FLAG_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state == IDLE && start) begin
      ovf_q <= 1'b0;
    end else if (state == SHIFT && last) begin
      ovf_q <= c ^ c_nxt;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub (WIDTH=8).
// Cycle-level behavioural model plus directed literal checks.
module tb_serial_add_sub;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         m;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .m        (m),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry_out(carry_out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  // model: operation accepted when idle, answer from plain arithmetic
  logic         m_busy;
  int           m_left;
  logic [W-1:0] m_res;
  logic         m_co;
  logic         m_ov;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_left = 0;
      m_res  = '0;
      m_co   = 1'b0;
      m_ov   = 1'b0;
    end else if (m_busy) begin
      m_left = m_left - 1;
      if (m_left == 0) m_busy = 1'b0;
    end else if (start) begin
      logic [W:0] full;
      m_busy = 1'b1;
      m_left = W + 1;
      if (!m) begin
        full  = {1'b0, a} + {1'b0, b};
        m_res = full[W-1:0];
        m_co  = full[W];
        m_ov  = (a[W-1] == b[W-1]) && (m_res[W-1] != a[W-1]);
      end else begin
        m_res = a - b;
        m_co  = (a < b);
        m_ov  = (a[W-1] != b[W-1]) && (m_res[W-1] != a[W-1]);
      end
`ifndef OVERFLOW_FLAG_EN
      m_ov = 1'b0;
`endif
    end
  end

  always @(negedge clk) begin
    logic exp_done;
    exp_done = m_busy && (m_left == 1);
    chk("busy", busy, m_busy);
    chk("done", done, exp_done);
    if (!m_busy || exp_done) begin
      chk("result", result, m_res);
      chk("carry_out", carry_out, m_co);
      chk("overflow", overflow, m_ov);
    end
  end

  task automatic start_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic im);
    @(negedge clk);
    a     = ia;
    b     = ib;
    m     = im;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = ~ia;
    b     = ~ib;
    m     = ~im;
  endtask

  task automatic wait_done(input string nm, input int lat0,
                           input logic [W-1:0] er, input logic eco,
                           input logic eov);
    int lat;
    lat = lat0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, lat, W + 1);
    chk({nm, "_result"}, result, er);
    chk({nm, "_carry"}, carry_out, eco);
    chk({nm, "_ovf"}, overflow, eov);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    m     = 1'b0;
    a     = '0;
    b     = '0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_carry", carry_out, 0);
    chk("rst_ovf", overflow, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    start_op(8'h3C, 8'h05, 1'b0);
    wait_done("add_3c_05", 1, 8'h41, 1'b0, 1'b0);
    start_op(8'hFF, 8'h01, 1'b0);
    wait_done("add_ff_01", 1, 8'h00, 1'b1, 1'b0);
    start_op(8'h05, 8'h03, 1'b1);
    wait_done("sub_05_03", 1, 8'h02, 1'b0, 1'b0);
    start_op(8'h03, 8'h05, 1'b1);
    wait_done("sub_03_05", 1, 8'hFE, 1'b1, 1'b0);
    start_op(8'hA5, 8'hA5, 1'b1);
    wait_done("sub_a5_a5", 1, 8'h00, 1'b0, 1'b0);

`ifdef OVERFLOW_FLAG_EN
    start_op(8'h7F, 8'h01, 1'b0);
    wait_done("ovf_7f_01", 1, 8'h80, 1'b0, 1'b1);
    start_op(8'h80, 8'h01, 1'b1);
    wait_done("ovf_80_01", 1, 8'h7F, 1'b0, 1'b1);
`else
    start_op(8'h7F, 8'h01, 1'b0);
    wait_done("ovf_7f_01", 1, 8'h80, 1'b0, 1'b0);
    start_op(8'h80, 8'h01, 1'b1);
    wait_done("ovf_80_01", 1, 8'h7F, 1'b0, 1'b0);
`endif
    start_op(8'h10, 8'h10, 1'b0);
    wait_done("add_10_10", 1, 8'h20, 1'b0, 1'b0);

    // second start three cycles into the op must be ignored
    start_op(8'h3C, 8'h05, 1'b0);
    repeat (2) @(negedge clk);
    a     = 8'hFF;
    b     = 8'hFF;
    m     = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore_start", 4, 8'h41, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("hold_result", result, 8'h41);
    chk("hold_busy", busy, 0);

    // asynchronous abort four cycles after start
    start_op(8'h12, 8'h34, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_result", result, 0);
    chk("abort_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_done", done, 0);
    start_op(8'h12, 8'h34, 1'b0);
    wait_done("after_abort", 1, 8'h46, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
